// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with a valid/ready handshake, a
// one-entry skid buffer, flush, and a write-back forwarding tap.
// Optional feature macro: MEM_WB_PERF_EN adds the stall_cycles and
// bubble_cycles performance counters.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready depends only on registered state (skid empty). The
// consumer may drop out_ready at any time. A dropped out_ready stops at most
// one further entry, which is held in the skid register.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_read_data,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [REG_AW-1:0] in_write_dest,
    input  logic [1:0]        in_wb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] alu_result,
    output logic [REG_AW-1:0] write_dest,
    output logic              reg_write,
    output logic              mem_to_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_en,
`ifdef MEM_WB_PERF_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       bubble_cycles,
`endif
    output logic [1:0]        dbg_state_o
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] out_rd_q, out_alu_q, skid_rd_q, skid_alu_q;
    logic [REG_AW-1:0] out_dest_q, skid_dest_q;
    logic [1:0]        out_wb_q, skid_wb_q;
    logic              accept, consume;
    logic              load_out_in, load_out_skid, load_skid;

    // The valid bits of OUT and SKID come from the state.
    assign out_valid   = (state_q != EMPTY);
    assign in_ready    = (state_q != FULL);
    assign accept      = in_valid && in_ready;
    assign consume     = out_valid && out_ready;
    assign dbg_state_o = state_q;

    // Next state and register load selects. A flush cancels every load this edge.
    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d     = ONE;
                    load_out_in = 1'b1;
                end
            end
            ONE: begin
                if (consume && accept) begin
                    load_out_in = 1'b1;
                end else if (consume) begin
                    state_d = EMPTY;
                end else if (accept) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end
            end
            FULL: begin
                if (consume) begin
                    state_d       = ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d       = EMPTY;
            load_out_in   = 1'b0;
            load_out_skid = 1'b0;
            load_skid     = 1'b0;
        end
    end

    // State and data registers. An empty register keeps its last data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            out_rd_q    <= '0;
            out_alu_q   <= '0;
            out_dest_q  <= '0;
            out_wb_q    <= '0;
            skid_rd_q   <= '0;
            skid_alu_q  <= '0;
            skid_dest_q <= '0;
            skid_wb_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load_out_in) begin
                out_rd_q   <= in_read_data;
                out_alu_q  <= in_alu_result;
                out_dest_q <= in_write_dest;
                out_wb_q   <= in_wb;
            end else if (load_out_skid) begin
                out_rd_q   <= skid_rd_q;
                out_alu_q  <= skid_alu_q;
                out_dest_q <= skid_dest_q;
                out_wb_q   <= skid_wb_q;
            end
            if (load_skid) begin
                skid_rd_q   <= in_read_data;
                skid_alu_q  <= in_alu_result;
                skid_dest_q <= in_write_dest;
                skid_wb_q   <= in_wb;
            end
        end
    end

    // Outputs decode the OUT register only. A bubble never writes and never forwards.
    assign read_data  = out_rd_q;
    assign alu_result = out_alu_q;
    assign write_dest = out_dest_q;
    assign mem_to_reg = out_wb_q[1];
    assign reg_write  = out_wb_q[0] && out_valid;
    assign wb_data    = out_wb_q[1] ? out_rd_q : out_alu_q;
    assign fwd_en     = reg_write && (out_dest_q != '0);

`ifdef MEM_WB_PERF_EN
    logic [31:0] stall_q, bubble_q;

    // Counters for stalled output and empty output. Only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid && !out_ready) stall_q <= stall_q + 32'd1;
            if (!out_valid)              bubble_q <= bubble_q + 32'd1;
        end
    end

    assign stall_cycles  = stall_q;
    assign bubble_cycles = bubble_q;
`endif

endmodule
